seq_multiplier_p: RTL and testbench

Parametrised iterative shift-add multiplier, one multiplier bit per cycle, producing a full 2W-bit product. It is the next generation of the core's W=32 MUL unit. It adds a mixed-sign mode (signed x × unsigned y), an explicit start/busy/done handshake and a synchronous reset. It sits beside the ALU and is stalled on by the CPU pipeline via `busy`.

---
 rtl/mul_pkg.sv | 9 +
 rtl/seq_multiplier_p_if.sv | 14 +
 rtl/mul_step.sv | 25 ++
 rtl/seq_multiplier_p.sv | 75 +++++++
 tb/tb_seq_multiplier_p.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared mode encodings and FSM state type for the sequential multiplier
//   MUL_UU/MUL_SS/MUL_SU : mode field values (2'b11 behaves as MUL_UU)
//   state_t              : IDLE / RUN / DONE
package mul_pkg;
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SS = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_multiplier_p_if.sv
// seq_multiplier_p_if: start/busy/done handshake and operand/product bus
//   start, mode, x, y : request side (master drives)
//   busy, done, z     : response side (slave drives)
interface seq_multiplier_p_if #(parameter int W = 32);
    logic           start;
    logic [1:0]     mode;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] z;
    modport master(output start, mode, x, y, input busy, done, z);
    modport slave(input start, mode, x, y, output busy, done, z);
endinterface

// File: rtl/mul_step.sv
// mul_step: one shift-add iteration, s = hi +/- (p0 ? y : 0) at W+1 bits
//   hi  : upper half of the partial product
//   p0  : current multiplier bit
//   y   : multiplicand
//   ys  : multiplicand is signed (sign-extend both terms)
//   sub : subtract instead of add (final step of a signed multiplier)
//   s   : W+1-bit sum forming the new upper part of the partial product
module mul_step #(parameter int W = 32) (
    input  logic [W-1:0] hi,
    input  logic         p0,
    input  logic [W-1:0] y,
    input  logic         ys,
    input  logic         sub,
    output logic [W:0]   s
);
    logic [W-1:0] w0;
    logic [W:0]   a;
    logic [W:0]   b;
    always_comb begin
        w0 = p0 ? y : '0;
        a  = {ys & hi[W-1], hi};
        b  = {ys & w0[W-1], w0};
        s  = sub ? a - b : a + b;
    end
endmodule

// File: rtl/seq_multiplier_p.sv
// seq_multiplier_p: iterative shift-add multiplier, one multiplier bit per cycle, 2W-bit product
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : slave side of seq_multiplier_p_if (start/mode/x/y in, busy/done/z out)
module seq_multiplier_p
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    seq_multiplier_p_if.slave   bus
);
    localparam int CW = $clog2(W) + 1;

    state_t         state;
    state_t         nxt;
    logic [2*W-1:0] p;
    logic [2*W-1:0] z_q;
    logic [W-1:0]   yr;
    logic           xs;
    logic           ys;
    logic [CW-1:0]  cnt;
    logic [W:0]     s;
    logic           last;
    logic           accept;

    assign last   = cnt == CW'(W - 1);
    assign accept = bus.start && state != RUN;

    // A signed multiplier's top bit carries weight -2^(W-1), so its partial product is subtracted
    mul_step #(.W(W)) u_step (
        .hi  (p[2*W-1:W]),
        .p0  (p[0]),
        .y   (yr),
        .ys  (ys),
        .sub (last && xs),
        .s   (s)
    );

    always_comb begin
        nxt = state;
        nxt = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            p     <= '0;
            yr    <= '0;
            xs    <= 1'b0;
            ys    <= 1'b0;
            cnt   <= '0;
            z_q   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                p   <= {{W{1'b0}}, bus.x};
                yr  <= bus.y;
                cnt <= '0;
                xs  <= bus.mode == MUL_SS || bus.mode == MUL_SU;
                ys  <= bus.mode == MUL_SS;
            end else if (state == RUN) begin
                p   <= {s, p[W-1:1]};
                cnt <= cnt + 1'b1;
                // z mirrors P outside RUN; capturing on the last step keeps the old result visible while iterating
                if (last) z_q <= {s, p[W-1:1]};
            end
        end
    end

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.z    = z_q;
endmodule

// File: tb/tb_seq_multiplier_p.sv
// tb_seq_multiplier_p: self-checking bench for seq_multiplier_p at W=32 and W=8
module tb_seq_multiplier_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_multiplier_p_if #(.W(32)) a();
    seq_multiplier_p_if #(.W(8))  b();

    seq_multiplier_p #(.W(32)) dut_a(.clk(clk), .rst(rst), .bus(a.slave));
    seq_multiplier_p #(.W(8))  dut_b(.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    // Reference: extend each operand to 64 bits by its signedness, multiply, keep 2w bits
    function automatic logic [63:0] model(input int w, input logic [1:0] m, input logic [63:0] xv, input logic [63:0] yv);
        logic [63:0] xe;
        logic [63:0] ye;
        logic [63:0] mask;
        logic [63:0] lo;
        bit xsg;
        bit ysg;
        xsg  = (m == 2'b01) || (m == 2'b10);
        ysg  = (m == 2'b01);
        lo   = (64'd1 << w) - 64'd1;
        mask = (w >= 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
        xe   = xv & lo;
        ye   = yv & lo;
        if (xsg && xv[w-1]) xe = xe | ~lo;
        if (ysg && yv[w-1]) ye = ye | ~lo;
        return (xe * ye) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_a(input logic [1:0] m, input logic [31:0] xv, input logic [31:0] yv);
        a.start = 1'b1; a.mode = m; a.x = xv; a.y = yv;
        tick();
        a.start = 1'b0;
    endtask

    task automatic go_b(input logic [1:0] m, input logic [7:0] xv, input logic [7:0] yv);
        b.start = 1'b1; b.mode = m; b.x = xv; b.y = yv;
        tick();
        b.start = 1'b0;
    endtask

    task automatic wait_a(output int bc, output bit got);
        bc = 0; got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (a.done) begin got = 1'b1; break; end
            if (a.busy) bc++;
            tick();
        end
    endtask

    task automatic wait_b(output int bc, output bit got);
        bc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (b.done) begin got = 1'b1; break; end
            if (b.busy) bc++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a.start = 0; a.mode = 0; a.x = 0; a.y = 0;
        b.start = 0; b.mode = 0; b.x = 0; b.y = 0;
        tick(); tick();
        n_cmp += 6;
        if (a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", a.busy); end
        if (a.done !== 1'b0) begin n_bad++; $display("FAIL reset_done_a: got %b want 0", a.done); end
        if (a.z !== 64'd0)   begin n_bad++; $display("FAIL reset_z_a: got %h want 0", a.z); end
        if (b.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b want 0", b.busy); end
        if (b.done !== 1'b0) begin n_bad++; $display("FAIL reset_done_b: got %b want 0", b.done); end
        if (b.z !== 16'd0)   begin n_bad++; $display("FAIL reset_z_b: got %h want 0", b.z); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_directed_w32();
        logic [1:0]  tm[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic [31:0] tx[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] ty[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [63:0] tz[4] = '{64'hFFFFFFFE00000001, 64'h0000000000000001,
                               64'h4000000000000000, 64'hFFFFFFFF00000001};
        int bc;
        bit got;
        for (int i = 0; i < 4; i++) begin
            go_a(tm[i], tx[i], ty[i]);
            wait_a(bc, got);
            n_cmp += 4;
            if (!got) begin n_bad++; $display("FAIL dir32_timeout[%0d]: got no done want done", i); end
            if (bc != 32) begin n_bad++; $display("FAIL dir32_busy_cycles[%0d]: got %0d want 32", i, bc); end
            if (a.z !== tz[i]) begin n_bad++; $display("FAIL dir32_z[%0d]: got %h want %h", i, a.z, tz[i]); end
            tick();
            if (a.done !== 1'b0 || a.z !== tz[i]) begin
                n_bad++; $display("FAIL dir32_pulse_hold[%0d]: got done=%b z=%h want done=0 z=%h", i, a.done, a.z, tz[i]);
            end
        end
    endtask

    task automatic test_directed_w8();
        logic [1:0]  tm[6] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01};
        logic [7:0]  tx[6] = '{8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h00};
        logic [7:0]  ty[6] = '{8'h7F, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h80};
        logic [15:0] tz[6] = '{16'hC080, 16'h3F80, 16'h4000, 16'hFE01, 16'h8080, 16'h0000};
        int bc;
        bit got;
        for (int i = 0; i < 6; i++) begin
            go_b(tm[i], tx[i], ty[i]);
            wait_b(bc, got);
            n_cmp += 3;
            if (!got) begin n_bad++; $display("FAIL dir8_timeout[%0d]: got no done want done", i); end
            if (bc != 8) begin n_bad++; $display("FAIL dir8_busy_cycles[%0d]: got %0d want 8", i, bc); end
            if (b.z !== tz[i]) begin n_bad++; $display("FAIL dir8_z[%0d]: got %h want %h", i, b.z, tz[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner[4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [63:0] prev_a;
        logic [63:0] exp_a;
        logic [15:0] exp_b;
        logic [31:0] xa, ya;
        logic [7:0]  xb, yb;
        logic [1:0]  m;
        int bc;
        bit got;
        for (int i = 0; i < 30; i++) begin
            m  = 2'($urandom_range(0, 3));
            xa = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            ya = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            xb = 8'($urandom);
            yb = 8'($urandom);
            exp_a = model(32, m, {32'd0, xa}, {32'd0, ya});
            exp_b = 16'(model(8, m, {56'd0, xb}, {56'd0, yb}));
            a.start = 1'b1; a.mode = m; a.x = xa; a.y = ya;
            b.start = 1'b1; b.mode = m; b.x = xb; b.y = yb;
            tick();
            a.start = 1'b0; b.start = 1'b0;
            if (i > 0) begin
                n_cmp++;
                if (a.z !== prev_a) begin n_bad++; $display("FAIL rnd_z_hold[%0d]: got %h want %h", i, a.z, prev_a); end
            end
            wait_a(bc, got);
            n_cmp += 3;
            if (!got) begin n_bad++; $display("FAIL rnd_timeout[%0d]: got no done want done", i); end
            if (a.z !== exp_a) begin n_bad++; $display("FAIL rnd_z32[%0d]: mode=%0d x=%h y=%h got %h want %h", i, m, xa, ya, a.z, exp_a); end
            if (b.z !== exp_b) begin n_bad++; $display("FAIL rnd_z8[%0d]: mode=%0d x=%h y=%h got %h want %h", i, m, xb, yb, b.z, exp_b); end
            prev_a = exp_a;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1;
        logic [63:0] e2;
        int bc;
        bit got;
        e1 = model(32, 2'b01, 64'h00000000DEADBEEF, 64'h0000000012345678);
        e2 = model(32, 2'b10, 64'h0000000087654321, 64'h00000000FEDCBA98);
        go_a(2'b01, 32'hDEADBEEF, 32'h12345678);
        repeat (4) tick();
        a.start = 1'b1; a.mode = 2'b00; a.x = 32'h11111111; a.y = 32'h22222222;
        tick();
        a.start = 1'b0;
        wait_a(bc, got);
        n_cmp += 3;
        if (!got) begin n_bad++; $display("FAIL b2b_timeout1: got no done want done"); end
        if (bc != 27) begin n_bad++; $display("FAIL b2b_busy_rest1: got %0d want 27", bc); end
        if (a.z !== e1) begin n_bad++; $display("FAIL b2b_ignore_start: got %h want %h", a.z, e1); end
        go_a(2'b10, 32'h87654321, 32'hFEDCBA98);
        n_cmp++;
        if (a.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_no_gap: got busy=%b want 1", a.busy); end
        wait_a(bc, got);
        n_cmp += 2;
        if (bc != 32) begin n_bad++; $display("FAIL b2b_busy2: got %0d want 32", bc); end
        if (a.z !== e2) begin n_bad++; $display("FAIL b2b_z2: got %h want %h", a.z, e2); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        int bc;
        bit got;
        go_a(2'b01, 32'hCAFEF00D, 32'h80000001);
        repeat (9) tick();
        rst = 1'b0;
        tick();
        n_cmp += 3;
        if (a.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", a.busy); end
        if (a.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", a.done); end
        if (a.z !== 64'd0)   begin n_bad++; $display("FAIL midrst_z: got %h want 0", a.z); end
        rst = 1'b1;
        tick();
        e = model(32, 2'b01, 64'h00000000CAFEF00D, 64'h0000000080000001);
        go_a(2'b01, 32'hCAFEF00D, 32'h80000001);
        wait_a(bc, got);
        n_cmp += 2;
        if (!got) begin n_bad++; $display("FAIL midrst_timeout: got no done want done"); end
        if (a.z !== e) begin n_bad++; $display("FAIL midrst_fresh: got %h want %h", a.z, e); end
    endtask

    initial begin
        test_reset();
        test_directed_w32();
        test_directed_w8();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
